// File: rtl/interrupt_flag.sv
// -----------------------------------------------------------------------------
// interrupt_flag
// One state bit with an asynchronous, active-high clear. The cell has two modes:
//   STICKY = 0 (load mode)   : q loads d on a rising clk edge when load_en = 1,
//                              and holds its value otherwise.
//   STICKY = 1 (sticky mode) : q sets to 1 on any rising clk edge where d = 1.
//                              Once set, only clr returns it to 0.
//                              load_en is ignored in this mode.
// Ports:
//   clk     - rising-edge clock
//   clr     - asynchronous, active-high clear
//   load_en - load enable (used in load mode only)
//   d       - data input, or set request in sticky mode
//   q       - flop output, with no combinational path from any input
// -----------------------------------------------------------------------------
module interrupt_flag #(
  parameter bit STICKY = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic load_en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 1'b0;
    end else if (STICKY) begin
      // Set-only: a zero on d never clears the flag.
      if (d) begin
        q <= 1'b1;
      end
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/interrupt_register.sv
// -----------------------------------------------------------------------------
// interrupt_register
// Captures four switch levels under a write strobe.
// Latches four button requests as sticky interrupt flags.
// Each output comes straight from its own flop.
// Inputs are sampled as they arrive. No synchronizer is added here, so
// synchronizing and debouncing the inputs is left to the surrounding design.
// Ports:
//   CLK                          - system clock (rising edge)
//   CLR                          - asynchronous, active-high clear of all state
//   Write                        - switch-capture enable
//   Sw0..Sw3                     - switch levels to capture
//   North/South/East/West_Button - interrupt request levels
//   Sw0_State..Sw3_State         - captured switch bits
//   *_Button_State               - sticky interrupt flags
// -----------------------------------------------------------------------------
module interrupt_register (
  input  logic CLK,
  input  logic CLR,
  input  logic Write,
  input  logic Sw0,
  input  logic Sw1,
  input  logic Sw2,
  input  logic Sw3,
  input  logic North_Button,
  input  logic South_Button,
  input  logic East_Button,
  input  logic West_Button,
  output logic Sw0_State,
  output logic Sw1_State,
  output logic Sw2_State,
  output logic Sw3_State,
  output logic North_Button_State,
  output logic South_Button_State,
  output logic East_Button_State,
  output logic West_Button_State
);

  // Bit order in the internal vectors: [0]=Sw0/North, [1]=Sw1/South,
  // [2]=Sw2/East, [3]=Sw3/West.
  logic [3:0] sw_in;
  logic [3:0] btn_in;
  logic [3:0] sw_state;
  logic [3:0] btn_state;

  assign sw_in  = {Sw3, Sw2, Sw1, Sw0};
  assign btn_in = {West_Button, East_Button, South_Button, North_Button};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cells
      interrupt_flag #(.STICKY(1'b0)) u_sw_flag (
        .clk     (CLK),
        .clr     (CLR),
        .load_en (Write),
        .d       (sw_in[gi]),
        .q       (sw_state[gi])
      );

      // Button flags do not depend on Write.
      // Their enable is tied high and the sticky cell ignores it.
      interrupt_flag #(.STICKY(1'b1)) u_btn_flag (
        .clk     (CLK),
        .clr     (CLR),
        .load_en (1'b1),
        .d       (btn_in[gi]),
        .q       (btn_state[gi])
      );
    end
  endgenerate

  assign Sw0_State          = sw_state[0];
  assign Sw1_State          = sw_state[1];
  assign Sw2_State          = sw_state[2];
  assign Sw3_State          = sw_state[3];
  assign North_Button_State = btn_state[0];
  assign South_Button_State = btn_state[1];
  assign East_Button_State  = btn_state[2];
  assign West_Button_State  = btn_state[3];

endmodule

// File: tb/tb_interrupt_register.sv
// -----------------------------------------------------------------------------
// tb_interrupt_register
// Directed scenarios with hand-computed expectations.
// The driver drives the inputs on the falling edge and pushes the expected
// output vector into a queue after the following rising edge.
// The monitor pops the queue on each falling edge and compares.
// Packing of the output vector: {W, E, S, N, Sw3, Sw2, Sw1, Sw0}.
// -----------------------------------------------------------------------------
module tb_interrupt_register;

  logic CLK = 1'b0;
  logic CLR;
  logic Write;
  logic Sw0, Sw1, Sw2, Sw3;
  logic North_Button, South_Button, East_Button, West_Button;
  logic Sw0_State, Sw1_State, Sw2_State, Sw3_State;
  logic North_Button_State, South_Button_State, East_Button_State, West_Button_State;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   drv_done = 1'b0;

  always #5 CLK = ~CLK;

  interrupt_register dut (
    .CLK                (CLK),
    .CLR                (CLR),
    .Write              (Write),
    .Sw0                (Sw0),
    .Sw1                (Sw1),
    .Sw2                (Sw2),
    .Sw3                (Sw3),
    .North_Button       (North_Button),
    .South_Button       (South_Button),
    .East_Button        (East_Button),
    .West_Button        (West_Button),
    .Sw0_State          (Sw0_State),
    .Sw1_State          (Sw1_State),
    .Sw2_State          (Sw2_State),
    .Sw3_State          (Sw3_State),
    .North_Button_State (North_Button_State),
    .South_Button_State (South_Button_State),
    .East_Button_State  (East_Button_State),
    .West_Button_State  (West_Button_State)
  );

  function automatic logic [7:0] outs();
    return {West_Button_State, East_Button_State, South_Button_State, North_Button_State,
            Sw3_State, Sw2_State, Sw1_State, Sw0_State};
  endfunction

  // Drive the inputs. sw = {Sw3..Sw0}, btn = {W, E, S, N}.
  task automatic drive(input logic wr, input logic [3:0] sw, input logic [3:0] btn);
    Write = wr;
    {Sw3, Sw2, Sw1, Sw0} = sw;
    {West_Button, East_Button, South_Button, North_Button} = btn;
  endtask

  task automatic expect_vec(input string name, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.exp  = exp;
    exp_q.push_back(c);
  endtask

  // Apply the inputs on a falling edge, wait for one rising edge, then queue the expected vector.
  task automatic step(input string name, input logic wr, input logic [3:0] sw,
                      input logic [3:0] btn, input logic [7:0] exp);
    @(negedge CLK);
    drive(wr, sw, btn);
    @(posedge CLK);
    #1;
    expect_vec(name, exp);
  endtask

  // Monitor / scoreboard.
  initial begin
    chk_t c;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        n_checks++;
        if (outs() === c.exp) begin
          n_pass++;
          $display("check %-14s got %b exp %b ok", c.name, outs(), c.exp);
        end else begin
          $display("FAIL %s got %b required %b", c.name, outs(), c.exp);
        end
      end
    end
  end

  // Driver.
  initial begin
    CLR = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000);
    #2;
    expect_vec("reset", 8'b0000_0000);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;

    // Scenario 1: load 1111, no buttons.
    step("s1_load1111", 1'b1, 4'b1111, 4'b0000, 8'b0000_1111);
    // Scenario 2: load 1010, all buttons pressed.
    step("s2_load_btns", 1'b1, 4'b1010, 4'b1111, 8'b1111_1010);
    // Scenario 3: Write=0. Only S and E are pressed, so every flag stays set.
    for (int i = 0; i < 3; i++)
      step($sformatf("s3_hold%0d", i), 1'b0, 4'b1010, 4'b0110, 8'b1111_1010);

    // Scenario 4: raise CLR between edges with all buttons pressed.
    @(negedge CLK);
    drive(1'b0, 4'b1010, 4'b1111);
    @(posedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    expect_vec("s4_async_clr", 8'b0000_0000);
    for (int i = 0; i < 2; i++)
      step($sformatf("s4_clr_hold%0d", i), 1'b0, 4'b1010, 4'b1111, 8'b0000_0000);
    step("s4_clr_vs_write", 1'b1, 4'b1111, 4'b1111, 8'b0000_0000);

    // Scenario 5: release CLR and press only West for one edge.
    @(negedge CLK);
    CLR = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000);
    step("s5_west_set", 1'b0, 4'b0000, 4'b1000, 8'b1000_0000);
    for (int i = 0; i < 2; i++)
      step($sformatf("s5_west_hold%0d", i), 1'b0, 4'b0000, 4'b0000, 8'b1000_0000);

    // Scenario 6: pulse Write with 0110, then change the switches with Write=0.
    step("s6_load0110", 1'b1, 4'b0110, 4'b0000, 8'b1000_0110);
    for (int i = 0; i < 2; i++)
      step($sformatf("s6_sw_hold%0d", i), 1'b0, 4'b1001, 4'b0000, 8'b1000_0110);

    drv_done = 1'b1;
  end

  // End of test, with a bounded wait for the scoreboard to drain.
  initial begin
    int budget;
    wait (drv_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge CLK);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Overall timeout so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout got running required finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
